// File: rtl/bam_pkg.sv
// Shared types and helpers for the sequential broken-array multiplier.
// Holds the FSM state enum, the per-bit keep mask and a bit-level reference model.
package bam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bam_state_e;

    // Keep bit for column col of partial-product row row; exact keeps everything.
    function automatic logic row_mask(input int row, input int col, input int v, input logic exact);
        return exact || ((col + row) >= v);
    endfunction

    // Sum of all kept partial-product bits, evaluated bit by bit over the full array.
    function automatic logic [63:0] bam_model(input logic [63:0] a, input logic [63:0] b,
                                              input int n, input int h, input int v,
                                              input logic exact);
        logic [63:0] sum;
        sum = '0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                if (a[i] && b[j] && (exact || (j >= h && (i + j) >= v)))
                    sum = sum + (64'd1 << (i + j));
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/bam_row_gen.sv
// One partial-product row of the broken array: operand a masked by the vertical
// break, gated by the multiplier bit and shifted into its column position.
module bam_row_gen
    import bam_pkg::*;
#(
    parameter int N = 8,
    parameter int V = 9
) (
    input  logic [N-1:0]         a_i,
    input  logic                 b_bit_i,
    input  logic [$clog2(N)-1:0] row_i,
    input  logic                 exact_i,
    output logic [2*N-1:0]       row_o
);

    logic [N-1:0] masked;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++)
            masked[i] = a_i[i] & row_mask(int'(row_i), i, V, exact_i);
        row_o = b_bit_i ? ({{N{1'b0}}, masked} << row_i) : '0;
    end

endmodule

// File: rtl/seq_bam_mul.sv
// Sequential broken-array approximate multiplier, unsigned N x N -> 2N,
// accumulating one partial-product row per cycle with valid/ready handshakes.
module seq_bam_mul
    import bam_pkg::*;
#(
    parameter int N = 8,
    parameter int H = 5,
    parameter int V = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           exact,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           busy
);

    localparam int RW = $clog2(N);

    if (N < 2) begin : g_bad_n
        $fatal(1, "seq_bam_mul: N must be >= 2");
    end
    if (H < 0 || H > N - 1) begin : g_bad_h
        $fatal(1, "seq_bam_mul: H must be in 0..N-1");
    end
    if (V < 0 || V > 2 * N - 2) begin : g_bad_v
        $fatal(1, "seq_bam_mul: V must be in 0..2N-2");
    end

    bam_state_e     state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic           exact_q, exact_d;
    logic [RW-1:0]  row_q, row_d;
    logic [2*N-1:0] acc_q, acc_d, result_q, result_d;
    logic [2*N-1:0] row_val;

    bam_row_gen #(.N(N), .V(V)) u_row_gen (
        .a_i     (a_q),
        .b_bit_i (b_q[row_q]),
        .row_i   (row_q),
        .exact_i (exact_q),
        .row_o   (row_val)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        exact_d  = exact_q;
        row_d    = row_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    exact_d = exact;
                    acc_d   = '0;
                    row_d   = exact ? '0 : RW'(H);
                    state_d = CALC;
                end
            end
            CALC: begin
                // Every row from the start row is visited, so latency is fixed.
                acc_d = acc_q + row_val;
                row_d = row_q + RW'(1);
                if (row_q == RW'(N - 1)) begin
                    result_d = acc_q + row_val;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            exact_q  <= 1'b0;
            row_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            exact_q  <= exact_d;
            row_q    <= row_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_seq_bam_mul.sv
// Scoreboard bench for seq_bam_mul at N=8, H=5, V=9: directed corner cases,
// backpressure, mid-operation reset and randomised operations.
module tb_seq_bam_mul;
    import bam_pkg::*;

    localparam int N = 8;
    localparam int H = 5;
    localparam int V = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           exact = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] result;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;
    logic [2*N-1:0] exp_q[$];

    always #5 clk = ~clk;

    seq_bam_mul #(.N(N), .H(H), .V(V)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .exact     (exact),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Output side of the scoreboard: pop on every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("unexpected_output", 64'(result), 64'hDEAD);
            else
                check("result", 64'(result), 64'(exp_q.pop_front()));
        end
    end

    // Called at posedge+1; returns at accept edge+1.
    task automatic start_op(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic ex);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        a = ai;
        b = bi;
        exact = ex;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input logic ex, input int rdelay);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), ex ? 64'(N) : 64'(N - H));
        repeat (rdelay) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_out", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic ex,
                          input logic [2*N-1:0] expv, input int rdelay);
        exp_q.push_back(expv);
        start_op(ai, bi, ex);
        finish_op(ex, rdelay);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic rex;
        int w;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed values
        run_op(8'hFF, 8'hFF, 1'b0, 16'hDA00, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 16'hFE01, 1);
        run_op(8'h10, 8'h20, 1'b0, 16'd512, 0);
        run_op(8'h08, 8'h20, 1'b0, 16'd0, 0);
        run_op(8'hFF, 8'h10, 1'b0, 16'd0, 2);
        run_op(8'hFF, 8'h10, 1'b1, 16'h0FF0, 0);

        // Backpressure with ignored input pulses
        exp_q.push_back(16'd512);
        start_op(8'h10, 8'h20, 1'b0);
        w = 0;
        while (!out_valid && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_result", 64'(result), 64'd512);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            a = 8'hFF;
            b = 8'hFF;
            exact = 1'b1;
            in_valid = (k % 2 == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_busy_after", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("bp_no_ghost_op", 64'(busy), 64'd0);

        // Reset in the middle of CALC
        start_op(8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_output", 64'(out_valid), 64'd0);
        run_op(8'd3, 8'd7, 1'b1, 16'd21, 0);

        // Random operations against the reference model
        for (int t = 0; t < 3000; t++) begin
            ra  = N'($urandom);
            rb  = N'($urandom);
            rex = 1'($urandom_range(0, 1));
            run_op(ra, rb, rex, (2*N)'(bam_model(64'(ra), 64'(rb), N, H, V, rex)),
                   int'($urandom_range(0, 3)));
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
